// File: rtl/sdram_port_arbiter_pkg.sv
// Shared memory-subsystem types for the Amstrad SDRAM path: requester ids,
// arbiter states, the latched command word and the ROM bank map.
package amstrad_mem_pkg;

   localparam int MEM_ADDR_W = 23;

   localparam logic [8:0] ROM_BANK_LOWER  = 9'h000;
   localparam logic [8:0] ROM_BANK_BASIC  = 9'h100;
   localparam logic [8:0] ROM_BANK_AMSDOS = 9'h107;
   localparam logic [8:0] ROM_BANK_LAST   = 9'h1ff;

   typedef enum logic [1:0] {
      P_VID = 2'd0,
      P_CPU = 2'd1,
      P_DL  = 2'd2
   } port_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic                  we;
      logic                  wide;
      logic [MEM_ADDR_W-1:0] addr;
      logic [1:0]            bank;
      logic [7:0]            din;
   } mem_cmd_t;

   function automatic logic [7:0] byte_select(input logic [15:0] word, input logic hi);
      return hi ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Command/response port between the arbiter and the sdram controller.
interface sdram_port_arbiter_if #(
   parameter int ADDR_W = 23
);
   logic              sd_req;
   logic              sd_we;
   logic              sd_wide;
   logic [ADDR_W-1:0] sd_addr;
   logic [1:0]        sd_bank;
   logic [7:0]        sd_din;
   logic [15:0]       sd_dout;
   logic              sd_rdy;

   modport master (
      output sd_req, sd_we, sd_wide, sd_addr, sd_bank, sd_din,
      input  sd_dout, sd_rdy
   );

   modport slave (
      input  sd_req, sd_we, sd_wide, sd_addr, sd_bank, sd_din,
      output sd_dout, sd_rdy
   );
endinterface

// File: rtl/sdram_port_arbiter_prio_sel.sv
// Fixed-priority select (video > CPU > downloader) with the downloader
// promoted above the CPU once it has been starved for STARVE_MAX CPU grants.
module arb_prio_sel
   import amstrad_mem_pkg::*;
#(
   parameter int STARVE_MAX = 8
) (
   input  logic       vid_elig,
   input  logic       cpu_elig,
   input  logic       dl_elig,
   input  logic [3:0] starve_cnt,
   output port_t      sel,
   output logic       valid
);

   logic dl_forced_s;

   assign dl_forced_s = dl_elig && (starve_cnt == 4'(STARVE_MAX));

   // video always wins; a starved downloader then beats the CPU
   always_comb begin
      sel   = P_VID;
      valid = 1'b0;
      if (vid_elig) begin
         sel   = P_VID;
         valid = 1'b1;
      end else if (dl_forced_s) begin
         sel   = P_DL;
         valid = 1'b1;
      end else if (cpu_elig) begin
         sel   = P_CPU;
         valid = 1'b1;
      end else if (dl_elig) begin
         sel   = P_DL;
         valid = 1'b1;
      end else begin
         sel   = P_VID;
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter (video, CPU, downloader) in front of the sdram command
// port, with per-port read holding registers, starvation guard and watchdog.
module sdram_port_arbiter
   import amstrad_mem_pkg::*;
#(
   parameter int ADDR_W     = 23,
   parameter int STARVE_MAX = 8,
   parameter int TIMEOUT    = 63
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_ack,
   output logic [15:0]       vid_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [1:0]        cpu_bank,
   input  logic [7:0]        cpu_din,
   output logic              cpu_ack,
   output logic [7:0]        cpu_data,
   input  logic              dl_req,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [1:0]        dl_bank,
   input  logic [7:0]        dl_din,
   output logic              dl_ack,
   output logic              err,
   sdram_port_arbiter_if.master sd
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   arb_state_t        state_r;
   arb_state_t        next_state_s;
   port_t             port_r;
   port_t             grant_s;
   logic              grant_valid_s;
   mem_cmd_t          cmd_r;
   mem_cmd_t          cmd_s;
   logic [3:0]        starve_r;
   logic [CNT_W-1:0]  wait_cnt_r;
   logic              sd_req_r;
   logic              vid_ack_r;
   logic              cpu_ack_r;
   logic              dl_ack_r;
   logic [15:0]       vid_data_r;
   logic [7:0]        cpu_data_r;
   logic              err_r;
   logic              vid_elig_s;
   logic              cpu_elig_s;
   logic              dl_elig_s;
   logic              grant_now_s;
   logic              rdy_s;
   logic              timeout_s;
   logic              finish_s;
   logic              vid_addr_unused_s;

   // a port acked this cycle may not be re-granted in the same decision
   assign vid_elig_s  = vid_req && !vid_ack_r;
   assign cpu_elig_s  = cpu_req && !cpu_ack_r;
   assign dl_elig_s   = dl_req  && !dl_ack_r;
   assign grant_now_s = (state_r == IDLE) && grant_valid_s;
   assign rdy_s       = (state_r == WAIT) && sd.sd_rdy;
   assign timeout_s   = (state_r == WAIT) && !sd.sd_rdy && (wait_cnt_r == CNT_W'(TIMEOUT));
   assign finish_s    = rdy_s || timeout_s;
   assign vid_addr_unused_s = vid_addr[0];

   arb_prio_sel #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio_sel (
      .vid_elig   (vid_elig_s),
      .cpu_elig   (cpu_elig_s),
      .dl_elig    (dl_elig_s),
      .starve_cnt (starve_r),
      .sel        (grant_s),
      .valid      (grant_valid_s)
   );

   // command word the winner would load into the command register
   always_comb begin
      cmd_s = '0;
      case (grant_s)
         P_VID: begin
            cmd_s.we   = 1'b0;
            cmd_s.wide = 1'b1;
            cmd_s.addr = MEM_ADDR_W'({vid_addr[ADDR_W-1:1], 1'b0});
            cmd_s.bank = 2'b00;
            cmd_s.din  = 8'h00;
         end
         P_CPU: begin
            cmd_s.we   = cpu_we;
            cmd_s.wide = 1'b0;
            cmd_s.addr = MEM_ADDR_W'(cpu_addr);
            cmd_s.bank = cpu_bank;
            cmd_s.din  = cpu_din;
         end
         P_DL: begin
            cmd_s.we   = 1'b1;
            cmd_s.wide = 1'b0;
            cmd_s.addr = MEM_ADDR_W'(dl_addr);
            cmd_s.bank = dl_bank;
            cmd_s.din  = dl_din;
         end
         default: begin
            cmd_s = '0;
         end
      endcase
   end

   // next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) begin
               next_state_s = ISSUE;
            end else begin
               next_state_s = IDLE;
            end
         end
         ISSUE: begin
            next_state_s = WAIT;
         end
         WAIT: begin
            if (finish_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = WAIT;
            end
         end
         DONE: begin
            next_state_s = IDLE;
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // state register and the watchdog counter, which reads 1 in the first WAIT cycle
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r    <= IDLE;
         wait_cnt_r <= '0;
      end else begin
         state_r <= next_state_s;
         if (state_r == ISSUE) begin
            wait_cnt_r <= CNT_W'(1);
         end else if (state_r == WAIT) begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end
   end

   // command capture, strobe and starvation bookkeeping
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cmd_r    <= '0;
         port_r   <= P_VID;
         starve_r <= 4'd0;
         sd_req_r <= 1'b0;
      end else begin
         sd_req_r <= grant_now_s;
         if (grant_now_s) begin
            cmd_r  <= cmd_s;
            port_r <= grant_s;
         end
         if (state_r == IDLE) begin
            if (!dl_req || (grant_valid_s && grant_s == P_DL)) begin
               starve_r <= 4'd0;
            end else if (grant_valid_s && grant_s == P_CPU && dl_elig_s && starve_r != 4'hF) begin
               starve_r <= starve_r + 4'd1;
            end
         end
      end
   end

   // completion: data holding registers, acks and the sticky error flag
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         vid_ack_r  <= 1'b0;
         cpu_ack_r  <= 1'b0;
         dl_ack_r   <= 1'b0;
         vid_data_r <= 16'h0000;
         cpu_data_r <= 8'h00;
         err_r      <= 1'b0;
      end else begin
         vid_ack_r <= finish_s && (port_r == P_VID);
         cpu_ack_r <= finish_s && (port_r == P_CPU);
         dl_ack_r  <= finish_s && (port_r == P_DL);
         if (rdy_s) begin
            if (port_r == P_VID) begin
               vid_data_r <= sd.sd_dout;
            end else if (port_r == P_CPU && !cmd_r.we) begin
               cpu_data_r <= byte_select(sd.sd_dout, cmd_r.addr[0]);
            end
         end
         if (timeout_s) begin
            err_r <= 1'b1;
            if (port_r == P_VID) begin
               vid_data_r <= 16'hFFFF;
            end else if (port_r == P_CPU && !cmd_r.we) begin
               cpu_data_r <= 8'hFF;
            end
         end
      end
   end

   assign sd.sd_req  = sd_req_r;
   assign sd.sd_we   = cmd_r.we;
   assign sd.sd_wide = cmd_r.wide;
   assign sd.sd_addr = cmd_r.addr[ADDR_W-1:0];
   assign sd.sd_bank = cmd_r.bank;
   assign sd.sd_din  = cmd_r.din;
   assign vid_ack    = vid_ack_r;
   assign cpu_ack    = cpu_ack_r;
   assign dl_ack     = dl_ack_r;
   assign vid_data   = vid_data_r;
   assign cpu_data   = cpu_data_r;
   assign err        = err_r;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter with a latency-programmable sdram responder.
module tb_sdram_port_arbiter;

   localparam int AW = 23;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_ack;
   logic [15:0]   vid_data;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [1:0]    cpu_bank;
   logic [7:0]    cpu_din;
   logic          cpu_ack;
   logic [7:0]    cpu_data;
   logic          dl_req;
   logic [AW-1:0] dl_addr;
   logic [1:0]    dl_bank;
   logic [7:0]    dl_din;
   logic          dl_ack;
   logic          err;

   logic          tb_sd_rdy  = 1'b0;
   logic [15:0]   tb_sd_dout = 16'hDEAD;
   int            rdy_lat    = 1;
   bit            rdy_never  = 1'b0;
   logic [15:0]   model_dout = 16'h0000;
   int            pend       = 0;

   int checks = 0;
   int errors = 0;

   always #5 clk_sys = ~clk_sys;

   sdram_port_arbiter_if #(.ADDR_W(AW)) sd_bus ();

   assign sd_bus.sd_rdy  = tb_sd_rdy;
   assign sd_bus.sd_dout = tb_sd_dout;

   sdram_port_arbiter #(
      .ADDR_W     (AW),
      .STARVE_MAX (8),
      .TIMEOUT    (63)
   ) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .vid_req  (vid_req),
      .vid_addr (vid_addr),
      .vid_ack  (vid_ack),
      .vid_data (vid_data),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_bank (cpu_bank),
      .cpu_din  (cpu_din),
      .cpu_ack  (cpu_ack),
      .cpu_data (cpu_data),
      .dl_req   (dl_req),
      .dl_addr  (dl_addr),
      .dl_bank  (dl_bank),
      .dl_din   (dl_din),
      .dl_ack   (dl_ack),
      .err      (err),
      .sd       (sd_bus)
   );

   // sdram model: sd_req seen in cycle k yields sd_rdy in cycle k+rdy_lat
   always @(negedge clk_sys) begin
      tb_sd_rdy  = 1'b0;
      tb_sd_dout = 16'hDEAD;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            tb_sd_rdy  = 1'b1;
            tb_sd_dout = model_dout;
         end
      end
      if (sd_bus.sd_req === 1'b1 && !rdy_never) pend = rdy_lat;
   end

   task automatic tick();
      @(negedge clk_sys);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({sd_bus.sd_req, sd_bus.sd_we, sd_bus.sd_wide} !== 3'b000) begin
         errors++; $display("FAIL reset_sd_ctrl: got %b want 000", {sd_bus.sd_req, sd_bus.sd_we, sd_bus.sd_wide});
      end
      checks++;
      if ({vid_ack, cpu_ack, dl_ack, err} !== 4'b0000) begin
         errors++; $display("FAIL reset_ack_err: got %b want 0000", {vid_ack, cpu_ack, dl_ack, err});
      end
      checks++;
      if (sd_bus.sd_addr !== 23'h000000 || sd_bus.sd_bank !== 2'b00 || sd_bus.sd_din !== 8'h00) begin
         errors++; $display("FAIL reset_cmd: got %h/%h/%h want 0/0/0", sd_bus.sd_addr, sd_bus.sd_bank, sd_bus.sd_din);
      end
      checks++;
      if (vid_data !== 16'h0000 || cpu_data !== 8'h00) begin
         errors++; $display("FAIL reset_data: got %h/%h want 0000/00", vid_data, cpu_data);
      end
      reset = 1'b0;
      repeat (2) tick();
      checks++;
      if (sd_bus.sd_req !== 1'b0) begin
         errors++; $display("FAIL idle_no_req: got %b want 0", sd_bus.sd_req);
      end
   endtask

   task automatic test_cpu_read();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000101; cpu_bank = 2'd1;
      rdy_lat = 4; model_dout = 16'hA55A;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) begin
            checks++;
            if ({sd_bus.sd_req, sd_bus.sd_we, sd_bus.sd_wide} !== 3'b100 || sd_bus.sd_addr !== 23'h000101 || sd_bus.sd_bank !== 2'd1) begin
               errors++; $display("FAIL cpu_issue: got req/we/wide %b addr %h bank %0d want 100 000101 1",
                  {sd_bus.sd_req, sd_bus.sd_we, sd_bus.sd_wide}, sd_bus.sd_addr, sd_bus.sd_bank);
            end
         end
         checks++;
         if (cpu_ack !== (c == 6)) begin
            errors++; $display("FAIL cpu_ack_cycle%0d: got %b want %b", c, cpu_ack, (c == 6));
         end
         if (c == 6) begin
            checks++;
            if (cpu_data !== 8'hA5) begin
               errors++; $display("FAIL cpu_data_hi: got %h want a5", cpu_data);
            end
            cpu_req = 1'b0;
         end
      end
   endtask

   task automatic test_rerequest();
      int acks = 0;
      int ack1 = -1;
      int req1 = -1;
      int req2 = -1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000200; cpu_bank = 2'd0;
      rdy_lat = 1; model_dout = 16'h5AC3;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (sd_bus.sd_req === 1'b1) begin
            if (req1 < 0) req1 = c; else if (req2 < 0) req2 = c;
         end
         if (cpu_ack === 1'b1) begin
            acks++;
            if (acks == 1) ack1 = c;
            if (acks == 2) cpu_req = 1'b0;
         end
      end
      checks++;
      if (req1 != 1 || ack1 != 3) begin
         errors++; $display("FAIL rereq_first: got req %0d ack %0d want 1 3", req1, ack1);
      end
      checks++;
      if (req2 != 5) begin
         errors++; $display("FAIL rereq_second_sd_req: got cycle %0d want 5", req2);
      end
      checks++;
      if (acks != 2 || cpu_data !== 8'hC3) begin
         errors++; $display("FAIL rereq_acks_data: got %0d/%h want 2/c3", acks, cpu_data);
      end
   endtask

   task automatic test_simultaneous();
      int vc = -1, cc = -1, dc = -1;
      int vn = 0, cn = 0, dn = 0;
      vid_req = 1'b1; vid_addr = 23'h000123;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000010; cpu_bank = 2'd0;
      dl_req  = 1'b1; dl_addr = 23'h004000; dl_bank = 2'd2; dl_din = 8'h77;
      rdy_lat = 1; model_dout = 16'hBEEF;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (sd_bus.sd_req === 1'b1 && sd_bus.sd_wide === 1'b1) begin
            checks++;
            if (sd_bus.sd_addr !== 23'h000122) begin
               errors++; $display("FAIL vid_word_addr: got %h want 000122", sd_bus.sd_addr);
            end
         end
         if (sd_bus.sd_req === 1'b1 && sd_bus.sd_we === 1'b1) begin
            checks++;
            if (sd_bus.sd_addr !== 23'h004000 || sd_bus.sd_bank !== 2'd2 || sd_bus.sd_din !== 8'h77) begin
               errors++; $display("FAIL dl_write_cmd: got %h/%0d/%h want 004000/2/77", sd_bus.sd_addr, sd_bus.sd_bank, sd_bus.sd_din);
            end
         end
         if (vid_ack === 1'b1) begin vn++; vc = c; vid_req = 1'b0; end
         if (cpu_ack === 1'b1) begin cn++; cc = c; cpu_req = 1'b0; end
         if (dl_ack === 1'b1) begin dn++; dc = c; dl_req = 1'b0; end
      end
      checks++;
      if (vc != 3 || cc != 7 || dc != 11) begin
         errors++; $display("FAIL simul_order: got vid %0d cpu %0d dl %0d want 3 7 11", vc, cc, dc);
      end
      checks++;
      if (vn != 1 || cn != 1 || dn != 1) begin
         errors++; $display("FAIL simul_ack_count: got %0d %0d %0d want 1 1 1", vn, cn, dn);
      end
      checks++;
      if (vid_data !== 16'hBEEF || cpu_data !== 8'hEF) begin
         errors++; $display("FAIL simul_data: got %h/%h want beef/ef", vid_data, cpu_data);
      end
   endtask

   task automatic test_starvation();
      bit seq_we [27];
      int grants = 0, cpu_acks = 0, dl_acks = 0;
      bit done = 1'b0;
      bit exp_we;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000050;
      dl_req  = 1'b1; dl_addr = 23'h001000; dl_bank = 2'd0; dl_din = 8'h11;
      rdy_lat = 1; model_dout = 16'h0102;
      for (int c = 1; c <= 200 && !done; c++) begin
         tick();
         if (sd_bus.sd_req === 1'b1) begin
            if (grants < 27) seq_we[grants] = sd_bus.sd_we;
            grants++;
         end
         if (cpu_ack === 1'b1) cpu_acks++;
         if (dl_ack === 1'b1) begin
            dl_acks++;
            if (dl_acks == 3) begin cpu_req = 1'b0; dl_req = 1'b0; done = 1'b1; end
         end
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL starve_bound: got %0d dl acks in 200 cycles want 3", dl_acks);
      end
      repeat (6) tick();
      checks++;
      if (grants != 27 || cpu_acks != 24) begin
         errors++; $display("FAIL starve_counts: got grants %0d cpu acks %0d want 27 24", grants, cpu_acks);
      end
      for (int i = 0; i < 27; i++) begin
         exp_we = ((i % 9) == 8);
         checks++;
         if (seq_we[i] !== exp_we) begin
            errors++; $display("FAIL starve_seq[%0d]: got we %b want %b", i, seq_we[i], exp_we);
         end
      end
   endtask

   task automatic test_timeout_edge();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000001;
      rdy_lat = 63; model_dout = 16'h3C00;
      for (int c = 1; c <= 66; c++) begin
         tick();
         if (c == 64) begin
            checks++;
            if (cpu_ack !== 1'b0) begin
               errors++; $display("FAIL edge_early_ack: got %b want 0", cpu_ack);
            end
         end
         if (c == 65) begin
            checks++;
            if (cpu_ack !== 1'b1 || cpu_data !== 8'h3C || err !== 1'b0) begin
               errors++; $display("FAIL edge_rdy_at_timeout: got ack %b data %h err %b want 1 3c 0", cpu_ack, cpu_data, err);
            end
            cpu_req = 1'b0;
         end
      end
   endtask

   task automatic test_timeout();
      rdy_never = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000002;
      for (int c = 1; c <= 66; c++) begin
         tick();
         if (c == 64) begin
            checks++;
            if (cpu_ack !== 1'b0 || err !== 1'b0) begin
               errors++; $display("FAIL to_before: got ack %b err %b want 0 0", cpu_ack, err);
            end
         end
         if (c == 65) begin
            checks++;
            if (cpu_ack !== 1'b1 || cpu_data !== 8'hFF || err !== 1'b1) begin
               errors++; $display("FAIL to_abort: got ack %b data %h err %b want 1 ff 1", cpu_ack, cpu_data, err);
            end
            cpu_req = 1'b0;
         end
      end
      rdy_never = 1'b0;
      repeat (5) tick();
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_sticky: got %b want 1", err);
      end
      vid_req = 1'b1; vid_addr = 23'h000401; rdy_lat = 2; model_dout = 16'hC0DE;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (c == 1) begin
            checks++;
            if (sd_bus.sd_req !== 1'b1 || sd_bus.sd_wide !== 1'b1 || sd_bus.sd_addr !== 23'h000400) begin
               errors++; $display("FAIL to_vid_issue: got req %b wide %b addr %h want 1 1 000400", sd_bus.sd_req, sd_bus.sd_wide, sd_bus.sd_addr);
            end
         end
         if (c == 4) begin
            checks++;
            if (vid_ack !== 1'b1 || vid_data !== 16'hC0DE || err !== 1'b1) begin
               errors++; $display("FAIL to_vid_after: got ack %b data %h err %b want 1 c0de 1", vid_ack, vid_data, err);
            end
            vid_req = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      int dl_acks = 0;
      int cc = -1;
      dl_req = 1'b1; dl_addr = 23'h000777; dl_bank = 2'd3; dl_din = 8'h42;
      rdy_lat = 10; model_dout = 16'h0000;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (dl_ack === 1'b1) dl_acks++;
         if (c == 4) reset = 1'b1;
         if (c == 5) begin
            checks++;
            if ({sd_bus.sd_req, sd_bus.sd_we, sd_bus.sd_wide, vid_ack, cpu_ack, dl_ack, err} !== 7'b0000000 ||
                sd_bus.sd_addr !== 23'h000000 || sd_bus.sd_bank !== 2'b00 || sd_bus.sd_din !== 8'h00 ||
                vid_data !== 16'h0000 || cpu_data !== 8'h00) begin
               errors++; $display("FAIL midreset_values: got ctl %b addr %h bank %0d din %h vd %h cd %h want all 0",
                  {sd_bus.sd_req, sd_bus.sd_we, sd_bus.sd_wide, vid_ack, cpu_ack, dl_ack, err},
                  sd_bus.sd_addr, sd_bus.sd_bank, sd_bus.sd_din, vid_data, cpu_data);
            end
            reset = 1'b0;
            dl_req = 1'b0;
         end
      end
      checks++;
      if (dl_acks != 0) begin
         errors++; $display("FAIL midreset_no_ack: got %0d dl acks want 0", dl_acks);
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 23'h000003; rdy_lat = 1; model_dout = 16'h9911;
      for (int c = 1; c <= 6; c++) begin
         tick();
         if (cpu_ack === 1'b1 && cc < 0) begin cc = c; cpu_req = 1'b0; end
      end
      checks++;
      if (cc != 3 || cpu_data !== 8'h99) begin
         errors++; $display("FAIL midreset_next_req: got ack %0d data %h want 3 99", cc, cpu_data);
      end
   endtask

   initial begin
      reset = 1'b1;
      vid_req = 1'b0; vid_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_bank = 2'd0; cpu_din = 8'h00;
      dl_req = 1'b0; dl_addr = '0; dl_bank = 2'd0; dl_din = 8'h00;
      test_reset();
      test_cpu_read();
      repeat (3) tick();
      test_rerequest();
      repeat (3) tick();
      test_simultaneous();
      repeat (3) tick();
      test_starvation();
      repeat (3) tick();
      test_timeout_edge();
      repeat (3) tick();
      test_timeout();
      repeat (3) tick();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1);
   end

endmodule
